// File: rtl/fp_addsub_scheduler.sv
// Two-port round-robin scheduler sequencing a shared FP add/sub datapath.
// Optional: FPSCHED_SPECIAL_BYPASS_EN short-circuits inf/NaN operands.
module fp_addsub_scheduler #(
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic              req_sub0,
  input  logic              req_sub1,
  input  logic [31:0]       req_a0,
  input  logic [31:0]       req_b0,
  input  logic [31:0]       req_a1,
  input  logic [31:0]       req_b1,
  output logic [31:0]       dp_a,
  output logic [31:0]       dp_b,
  output logic              dp_eop,
  output logic [STAGES-1:0] dp_en,
  input  logic [31:0]       dp_result,
  input  logic              dp_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [31:0]       rsp_result,
  output logic [2:0]        rsp_flags,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_EXC   = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]  r_state;
  logic        r_last;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_eop;
  logic        r_id;
  logic [31:0] r_res;
  logic [2:0]  r_flags;

  logic        w_accept;
  logic        w_g;
  logic        w_sub;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_eop;
  logic        w_byp;
  logic [31:0] w_byp_res;
  logic [2:0]  w_byp_flags;
  logic [2:0]  w_exc_flags;

  // Contested grant goes to whoever did not win last time.
  assign w_g = (req_valid == 2'b11) ? ~r_last : ~req_valid[0];
  assign w_accept = (r_state == S_IDLE) && (|req_valid) && !rst;

  assign w_sub = w_g ? req_sub1 : req_sub0;
  assign w_a   = w_g ? req_a1 : req_a0;
  assign w_b   = w_g ? req_b1 : req_b0;
  assign w_eop = w_sub ^ w_a[31] ^ w_b[31];

  assign req_ready = !w_accept ? 2'b00 :
                     (w_g ? 2'b10 : 2'b01);

  assign w_exc_flags[0] = dp_ovf;
  assign w_exc_flags[1] = (dp_result[30:0] == 31'd0);
  assign w_exc_flags[2] = (dp_result[30:23] == 8'hFF) &&
                          (dp_result[22:0] != 23'd0);

`ifdef FPSCHED_SPECIAL_BYPASS_EN
  logic w_a_max;
  logic w_b_max;
  logic w_a_nan;
  logic w_b_nan;
  logic w_a_inf;
  logic w_b_inf;
  logic w_qnan;

  assign w_a_max = (w_a[30:23] == 8'hFF);
  assign w_b_max = (w_b[30:23] == 8'hFF);
  assign w_a_nan = w_a_max && (w_a[22:0] != 23'd0);
  assign w_b_nan = w_b_max && (w_b[22:0] != 23'd0);
  assign w_a_inf = w_a_max && (w_a[22:0] == 23'd0);
  assign w_b_inf = w_b_max && (w_b[22:0] == 23'd0);
  assign w_byp   = w_a_max || w_b_max;
  // inf - inf (effective) is invalid, same as a NaN input.
  assign w_qnan  = w_a_nan || w_b_nan ||
                   (w_a_inf && w_b_inf && w_eop);

  always_comb begin
    w_byp_res   = 32'h7F80_0001;
    w_byp_flags = 3'b100;
    if (!w_qnan) begin
      w_byp_flags = 3'b001;
      if (w_a_inf) begin
        w_byp_res = w_a;
      end else begin
        w_byp_res = {w_b[31] ^ w_sub, w_b[30:0]};
      end
    end
  end
`else
  assign w_byp       = 1'b0;
  assign w_byp_res   = 32'd0;
  assign w_byp_flags = 3'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_eop   <= 1'b0;
      r_id    <= 1'b0;
      r_res   <= 32'd0;
      r_flags <= 3'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= w_a;
            r_b    <= w_b;
            r_eop  <= w_eop;
            r_id   <= w_g;
            r_last <= w_g;
            if (w_byp) begin
              r_res   <= w_byp_res;
              r_flags <= w_byp_flags;
              r_state <= S_RESP;
            end else begin
              r_state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: r_state <= S_ADD;
        S_ADD:   r_state <= S_NORM;
        S_NORM:  r_state <= S_EXC;
        S_EXC: begin
          r_res   <= dp_result;
          r_flags <= w_exc_flags;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dp_en = '0;
    unique case (r_state)
      S_ALIGN: dp_en[0] = 1'b1;
      S_ADD:   dp_en[1] = 1'b1;
      S_NORM:  dp_en[2] = 1'b1;
      S_EXC:   dp_en[3] = 1'b1;
      default: dp_en = '0;
    endcase
  end

  assign dp_a       = r_a;
  assign dp_b       = r_b;
  assign dp_eop     = r_eop;
  assign rsp_id     = r_id;
  assign rsp_result = r_res;
  assign rsp_flags  = r_flags;
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Self-checking bench for fp_addsub_scheduler.
// Directed and random ops checked against a transaction-level model.
module tb_fp_addsub_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic        req_sub0 = 1'b0;
  logic        req_sub1 = 1'b0;
  logic [31:0] req_a0 = '0;
  logic [31:0] req_b0 = '0;
  logic [31:0] req_a1 = '0;
  logic [31:0] req_b1 = '0;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic        dp_eop;
  logic [3:0]  dp_en;
  logic [31:0] dp_result = '0;
  logic        dp_ovf = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;
  logic m_last = 1'b1;

  always #5 clk = ~clk;

  fp_addsub_scheduler #(.STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sub0(req_sub0), .req_sub1(req_sub1),
    .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1),
    .dp_a(dp_a), .dp_b(dp_b), .dp_eop(dp_eop),
    .dp_en(dp_en), .dp_result(dp_result),
    .dp_ovf(dp_ovf), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction

  // Called just after a rising edge; returns just after a rising edge
  // with the DUT back in IDLE.
  task automatic op(input logic [1:0] v,
                    input logic s0, input logic [31:0] a0,
                    input logic [31:0] b0,
                    input logic s1, input logic [31:0] a1,
                    input logic [31:0] b1,
                    input logic [31:0] res, input logic ovf,
                    input int stall, input logic keep);
    logic g;
    logic s;
    logic e;
    logic byp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] xr;
    logic [2:0] xf;
    req_valid = v;
    req_sub0 = s0; req_a0 = a0; req_b0 = b0;
    req_sub1 = s1; req_a1 = a1; req_b1 = b1;
    dp_result = res; dp_ovf = ovf; rsp_ready = 1'b0;
    if (v == 2'b11) g = ~m_last;
    else g = v[1];
    s = g ? s1 : s0;
    a = g ? a1 : a0;
    b = g ? b1 : b0;
    e = s ^ a[31] ^ b[31];
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("grant", {30'd0, req_ready}, g ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    m_last = g;
    if (!keep) req_valid = 2'b00;
    byp = 1'b0;
`ifdef FPSCHED_SPECIAL_BYPASS_EN
    byp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
`endif
    if (byp) begin
      if (is_nan(a) || is_nan(b) ||
          (is_inf(a) && is_inf(b) && e)) begin
        xr = 32'h7F800001; xf = 3'b100;
      end else if (is_inf(a)) begin
        xr = a; xf = 3'b001;
      end else begin
        xr = {b[31] ^ s, b[30:0]}; xf = 3'b001;
      end
    end else begin
      xr = res;
      xf = {is_nan(res), (res & 32'h7FFFFFFF) == 0, ovf};
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("stage_en", {28'd0, dp_en}, 32'd1 << k);
        chk("stage_ready", {30'd0, req_ready}, 32'd0);
        chk("stage_busy", {31'd0, busy}, 32'd1);
        if (k == 0) begin
          chk("dp_a", dp_a, a);
          chk("dp_b", dp_b, b);
          chk("dp_eop", {31'd0, dp_eop}, {31'd0, e});
        end
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_result", rsp_result, xr);
      chk("rsp_flags", {29'd0, rsp_flags}, {29'd0, xf});
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, g});
      chk("rsp_ready_blk", {30'd0, req_ready}, 32'd0);
      chk("rsp_en", {28'd0, dp_en}, 32'd0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    req_valid = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_en", {28'd0, dp_en}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_dp_a", dp_a, 32'd0);
    chk("rst_dp_b", dp_b, 32'd0);
    chk("rst_eop", {31'd0, dp_eop}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_flags", {29'd0, rsp_flags}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b00;

    op(2'b01, 1'b0, 32'h3F800000, 32'h40000000,
       1'b0, 32'h0, 32'h0, 32'h40400000, 1'b0, 0, 1'b0);

    for (int i = 0; i < 4; i++)
      op(2'b11, 1'b0, 32'h3F800000, 32'hC0000000,
         1'b1, 32'h41200000, 32'h40A00000,
         32'h40A00000, 1'b0, 0, 1'b1);

    op(2'b10, 1'b1, 32'h0, 32'h0,
       1'b1, 32'h40000000, 32'h3F800000,
       32'h3F800000, 1'b0, 3, 1'b0);

    op(2'b01, 1'b0, 32'h7F000000, 32'h7F000000,
       1'b0, 32'h0, 32'h0, 32'h7F800000, 1'b1, 0, 1'b0);
    op(2'b01, 1'b1, 32'h3F800000, 32'h3F800000,
       1'b0, 32'h0, 32'h0, 32'h00000000, 1'b0, 0, 1'b0);
    op(2'b10, 1'b0, 32'h0, 32'h0,
       1'b0, 32'h3F800000, 32'h40000000,
       32'h7FC00000, 1'b0, 1, 1'b0);

    // reset while in NORM, with a request pair present
    req_valid = 2'b10; req_a1 = 32'h3F800000;
    req_b1 = 32'h3F800000; req_sub1 = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("pre_rst_norm", {28'd0, dp_en}, 32'd4);
    chk("rst_cycle_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b00;
    m_last = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_en", {28'd0, dp_en}, 32'd0);
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
    chk("post_rst_dp_a", dp_a, 32'd0);
    @(posedge clk); #1;
    op(2'b11, 1'b0, 32'h40000000, 32'h40000000,
       1'b0, 32'h40400000, 32'h40400000,
       32'h40800000, 1'b0, 0, 1'b0);

`ifdef FPSCHED_SPECIAL_BYPASS_EN
    op(2'b01, 1'b1, 32'h7F800000, 32'h7F800000,
       1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    op(2'b10, 1'b0, 32'h0, 32'h0,
       1'b1, 32'h3F800000, 32'h7F800000,
       32'h0, 1'b0, 1, 1'b0);
`endif

    for (int i = 0; i < 12; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[30:23] = 8'hFF;
      if ($urandom_range(0, 3) == 0) r[30:0] = 31'd0;
      op(2'($urandom_range(1, 3)),
         1'($urandom), $urandom, $urandom,
         1'($urandom), $urandom, $urandom,
         r, 1'($urandom), $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_addsub_scheduler.md
# fp_addsub_scheduler

Arbitrates two requesters (host port 0 and port 1) sharing the single floating-point add/subtract datapath, and sequences that datapath through its align, add, normalize and exception-handling stages. Each request is accepted with a valid/ready handshake and processed to completion. The result is held on a response port with IEEE-754 single-precision status flags until the response is consumed. The block sits between the co-processor's command decode and the add/sub datapath, whose final stage is the exception/special-condition handler.

## Interface
Parameters:
- STAGES, 4: number of datapath stages sequenced (align, add, normalize, exception); fixed at 4 in this revision.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; at most one bit high; reset 0.
- req_sub0, req_sub1  input  1 each  requester's operation: 1 = subtract, 0 = add.
- req_a0, req_b0, req_a1, req_b1  input  32 each  requester operands, IEEE-754 single precision.
- dp_a, dp_b  output  32 each  latched operands to the datapath; reset 0.
- dp_eop  output  1  effective operation to the datapath: sub ^ a[31] ^ b[31]; reset 0.
- dp_en  output  4  one-hot stage enable: bit0 align, bit1 add, bit2 normalize, bit3 exception; reset 0.
- dp_result  input  32  datapath result, valid during the exception stage.
- dp_ovf  input  1  datapath overflow indication, valid during the exception stage.
- rsp_valid  output  1  response valid; reset 0.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  index of the requester that owns the response; reset 0.
- rsp_result  output  32  result; reset 0.
- rsp_flags  output  3  bit0 overflow, bit1 zero, bit2 NaN; reset 0.
- busy  output  1  high in every state except IDLE; reset 0.

## Operation
- States: IDLE, ALIGN, ADD, NORM, EXC, RESP. Reset enters IDLE.
- IDLE, arbitration:
  - Round-robin using a last_grant register, which resets to 1 so requester 0 wins the first contest.
  - If exactly one req_valid bit is set, that requester is granted.
  - If both bits are set, the requester not equal to last_grant is granted.
  - req_ready[g] is driven combinationally high in IDLE for the granted requester g.
- Accept: on an accepted request, the block latches:
  - operands into dp_a and dp_b;
  - dp_eop;
  - rsp_id = g;
  - last_grant = g.
  The FSM then moves to ALIGN.
- ALIGN, ADD, NORM, EXC: each lasts exactly one cycle and asserts the matching dp_en bit; exactly one bit is set in each of these states.
- EXC capture: at the end of EXC, the block captures:
  - rsp_result = dp_result;
  - flags[0] = dp_ovf;
  - flags[1] = (dp_result[30:0] == 0);
  - flags[2] = (dp_result[30:23] == 8'hFF && dp_result[22:0] != 0).
  The FSM then moves to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_result, rsp_flags and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that handshake, the FSM returns to IDLE and rsp_valid deasserts the next cycle.
- No new request is accepted outside IDLE; req_ready is 0 in every other state.
- Requesters must hold req_valid and operands until accepted. Dropping req_valid before acceptance simply withdraws the request.

## Timing
- Acceptance in cycle 0 gives: ALIGN in cycle 1, ADD in cycle 2, NORM in cycle 3, EXC in cycle 4, and rsp_valid high from cycle 5.
- Minimum accept-to-response latency is 5 cycles.
- If rsp_ready is high in cycle 5, the FSM is in IDLE in cycle 6. The next request can be accepted in cycle 6, giving a peak throughput of one operation per 6 cycles.
- Backpressure: each cycle rsp_ready stays low extends RESP by one cycle.
- Reset mid-operation, in any state:
  - the next cycle is IDLE;
  - all outputs take their reset values;
  - any in-flight result is discarded;
  - last_grant returns to 1.
- A request arriving in the same cycle as rst is ignored.

## Configuration
- FPSCHED_SPECIAL_BYPASS_EN:
  - Defined: in IDLE, if either operand of the granted request has exponent 8'hFF, the datapath is skipped. The FSM goes directly from IDLE to RESP, so the response is valid in cycle 1, and dp_en stays 0.
  - Bypass result selection, first match wins:
    1. Any NaN operand gives 32'h7F800001.
    2. Both operands infinite with dp_eop = 1 gives 32'h7F800001.
    3. Otherwise, the infinite operand, with b's sign flipped when req_sub is 1 and b is the infinite operand.
  - Bypass flags: NaN results give 3'b100; infinite results give 3'b001.
  - Not defined: every request traverses all four stages, and special operands are handled by the datapath.

## Test plan
- Single add on port 0: a = 0x3F800000, b = 0x40000000, dp_result driven to 0x40400000 in EXC -> req_ready[0] in cycle 0, dp_en = 1, 2, 4, 8 in cycles 1–4, rsp_valid in cycle 5 with rsp_result = 0x40400000, flags = 0, rsp_id = 0.
- Both ports valid continuously with rsp_ready = 1 -> grants alternate 0, 1, 0, 1, each grant 6 cycles apart.
- rsp_ready held low for 3 cycles in RESP -> rsp_valid, rsp_result and rsp_id stay stable for 4 cycles, and req_ready stays 0 throughout.
- dp_ovf = 1 with dp_result = 0x7F800000 -> flags = 3'b001; dp_result = 0x00000000 -> flags = 3'b010; dp_result = 0x7FC00000 -> flags = 3'b100.
- rst asserted during NORM -> the next cycle shows IDLE, dp_en = 0, busy = 0 and rsp_valid = 0; the following simultaneous request pair grants port 0.
- With FPSCHED_SPECIAL_BYPASS_EN defined: a = 0x7F800000, b = 0x7F800000, req_sub = 1 -> rsp_valid in cycle 1, rsp_result = 0x7F800001, flags = 3'b100, dp_en never nonzero.
